aes_trig_seq_detector: RTL

- Upstream stage of the 20-bit LFSR counter in the AES test-benchmark build.
- Monitors 128-bit plaintext blocks as they are loaded into the AES core and detects an ordered sequence of four configured block values.
- Drives the LFSR enable (Tj_Trig) once the full sequence has been observed.
- Includes a gap timeout so a partially matched sequence is discarded if loads stop arriving.

---
 rtl/aes_trig_seq_detector.sv | 97 +++++++++
 1 files changed

// File: rtl/aes_trig_seq_detector.sv
// Watches plaintext loads for an ordered four-block sequence and then
// latches the LFSR enable. Ports: clk, rst, state_vld, state, Tj_Trig, trig_pulse, progress.
module aes_trig_seq_detector #(
  parameter logic [127:0] PAT0 = 128'h3243f6a8885a308d313198a2e0370734,
  parameter logic [127:0] PAT1 = 128'h00112233445566778899aabbccddeeff,
  parameter logic [127:0] PAT2 = 128'h0,
  parameter logic [127:0] PAT3 = 128'h1,
  parameter int unsigned  MAX_GAP = 1024,
  parameter int unsigned  GAP_W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         state_vld,
  input  logic [127:0] state,
  output logic         Tj_Trig,
  output logic         trig_pulse,
  output logic [2:0]   progress
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    M1    = 3'd1,
    M2    = 3'd2,
    M3    = 3'd3,
    ARMED = 3'd4
  } fsm_e;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MAX_GAP - 1);

  fsm_e             fsm_q, fsm_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             trig_q, trig_d;
  logic             pulse_q, pulse_d;

  logic hit0, hit1, hit2, hit3;

  // Gating with state_vld keeps an undriven bus out of the next state.
  assign hit0 = state_vld && (state == PAT0);
  assign hit1 = state_vld && (state == PAT1);
  assign hit2 = state_vld && (state == PAT2);
  assign hit3 = state_vld && (state == PAT3);

  always_comb begin
    fsm_d   = fsm_q;
    gap_d   = '0;
    trig_d  = trig_q;
    pulse_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (hit0) fsm_d = M1;
      end
      M1, M2, M3: begin
        if (state_vld) begin
          // Advancing takes priority over restarting on PAT0.
          fsm_d = IDLE;
          if (hit0) fsm_d = M1;
          if (fsm_q == M1 && hit1) fsm_d = M2;
          if (fsm_q == M2 && hit2) fsm_d = M3;
          if (fsm_q == M3 && hit3) fsm_d = ARMED;
        end else if (gap_q == GAP_LAST) begin
          fsm_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ARMED: begin
        fsm_d = ARMED;
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase
    if (fsm_d == ARMED && fsm_q != ARMED) begin
      trig_d  = 1'b1;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      gap_q   <= '0;
      trig_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      gap_q   <= gap_d;
      trig_q  <= trig_d;
      pulse_q <= pulse_d;
    end
  end

  assign Tj_Trig    = trig_q;
  assign trig_pulse = pulse_q;
  assign progress   = fsm_q;

endmodule
